debounce_multi: RTL and testbench

- Parametrised N-channel debouncer for push-buttons and switches; next generation of the single-channel debounce block.
- Per channel: reset-able synchroniser, stability counter, clean debounced level.
- Adds one-cycle press/release pulses, a press-toggle output and a one-shot long-press pulse.
- Sits between board button pins and the FSMs and user logic that consume button events.

---
 rtl/debounce_channel.sv | 104 ++++++++++
 rtl/debounce_multi.sv | 37 +++
 tb/tb_debounce_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_channel.sv
// One debounced button channel: resettable synchroniser, stability counter,
// edge pulses, press toggle and one-shot long-press detection.
module debounce_channel #(
    parameter int unsigned DELAY_COUNTS = 2500,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned ACTIVE_LOW   = 0,
    parameter int unsigned LONG_COUNTS  = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(DELAY_COUNTS + 1);
    localparam int unsigned LP_W  = $clog2(LONG_COUNTS + 1);

    localparam logic             IDLE    = 1'(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_COUNTS - 1);
    localparam logic [LP_W-1:0]  LP_MAX  = LP_W'(LONG_COUNTS);
    localparam logic [LP_W-1:0]  LP_PRE  = LP_W'(LONG_COUNTS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LP_W-1:0]        hold_q, hold_d;
    logic                   pressed_q, pressed_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   release_pulse_q, release_pulse_d;
    logic                   toggle_q, toggle_d;
    logic                   long_press_q, long_press_d;
    logic                   flip_c;

    // Next-state: qualification, edge pulses and hold tracking
    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], button};
        stable_d        = stable_q;
        cnt_d           = '0;
        flip_c          = 1'b0;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        toggle_d        = toggle_q;
        hold_d          = hold_q;
        long_press_d    = 1'b0;

        if (sync_q[SYNC_STAGES-1] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[SYNC_STAGES-1];
                flip_c   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        pressed_d       = stable_d ^ IDLE;
        press_pulse_d   = flip_c & pressed_d;
        release_pulse_d = flip_c & ~pressed_d;
        toggle_d        = toggle_q ^ press_pulse_d;

        // A release on the saturating edge suppresses the long-press pulse
        if (!pressed_q || release_pulse_d) begin
            hold_d = '0;
        end else if (hold_q != LP_MAX) begin
            hold_d = hold_q + LP_W'(1);
        end
        long_press_d = pressed_q & ~release_pulse_d & (hold_q == LP_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= {SYNC_STAGES{IDLE}};
            stable_q        <= IDLE;
            cnt_q           <= '0;
            hold_q          <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            toggle_q        <= 1'b0;
            long_press_q    <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            stable_q        <= stable_d;
            cnt_q           <= cnt_d;
            hold_q          <= hold_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            toggle_q        <= toggle_d;
            long_press_q    <= long_press_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign toggle        = toggle_q;
    assign long_press    = long_press_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer; each channel is an independent debounce_channel.
module debounce_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DELAY_COUNTS = 2500,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned ACTIVE_LOW   = 0,
    parameter int unsigned LONG_COUNTS  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] button,
    output logic [NUM_CH-1:0] pressed,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] toggle,
    output logic [NUM_CH-1:0] long_press
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DELAY_COUNTS (DELAY_COUNTS),
            .SYNC_STAGES  (SYNC_STAGES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .LONG_COUNTS  (LONG_COUNTS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .button        (button[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .toggle        (toggle[i]),
            .long_press    (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a window-based reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_debounce_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DC     = 4;
    localparam int unsigned SS     = 2;
    localparam int unsigned AL     = 0;
    localparam int unsigned LC     = 10;
    localparam int unsigned HLEN   = SS + DC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] button;
    logic [NUM_CH-1:0] pressed, press_pulse, release_pulse, toggle, long_press;

    typedef struct packed {
        logic [NUM_CH-1:0] pressed;
        logic [NUM_CH-1:0] pp;
        logic [NUM_CH-1:0] rp;
        logic [NUM_CH-1:0] tg;
        logic [NUM_CH-1:0] lp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    debounce_multi #(
        .NUM_CH       (NUM_CH),
        .DELAY_COUNTS (DC),
        .SYNC_STAGES  (SS),
        .ACTIVE_LOW   (AL),
        .LONG_COUNTS  (LC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle        (toggle),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    // Reference model: raw history per channel; the level flips once the
    // DC synchronised samples seen so far all disagree with the current level.
    bit hist [NUM_CH][HLEN];
    bit m_stable [NUM_CH];
    bit m_toggle [NUM_CH];
    int m_age [NUM_CH];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < HLEN; j++) hist[c][j] = 1'(AL);
            m_stable[c] = 1'(AL);
            m_toggle[c] = 1'b0;
            m_age[c]    = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   old_p, new_p, all_diff;
        e = '0;
        if (!rst_n) begin
            model_reset();
            if (clk) exp_q.push_back(e);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                old_p    = m_stable[c] ^ 1'(AL);
                all_diff = 1'b1;
                for (int j = 1; j <= DC; j++)
                    if (hist[c][j] == m_stable[c]) all_diff = 1'b0;
                if (all_diff) m_stable[c] = ~m_stable[c];
                new_p = m_stable[c] ^ 1'(AL);
                for (int j = 0; j < HLEN - 1; j++) hist[c][j] = hist[c][j+1];
                hist[c][HLEN-1] = button[c];

                if (new_p && old_p) m_age[c] = m_age[c] + 1;
                else                m_age[c] = 0;

                e.pressed[c] = new_p;
                e.pp[c]      = new_p & ~old_p;
                e.rp[c]      = old_p & ~new_p;
                if (e.pp[c]) m_toggle[c] = ~m_toggle[c];
                e.tg[c]      = m_toggle[c];
                e.lp[c]      = new_p && old_p && (m_age[c] == int'(LC));
            end
            exp_q.push_back(e);
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e, got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {pressed, press_pulse, release_pulse, toggle, long_press};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL cycle_check t=%0t got p=%b pp=%b rp=%b tg=%b lp=%b exp p=%b pp=%b rp=%b tg=%b lp=%b",
                         $time, got.pressed, got.pp, got.rp, got.tg, got.lp,
                         e.pressed, e.pp, e.rp, e.tg, e.lp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_ch(input int c, input bit v, input int n);
        button[c] = v;
        step(n);
    endtask

    int rem [NUM_CH];

    initial begin
        rst_n  = 1'b0;
        button = '0;
        step(3);
        rst_n = 1'b1;
        step(20);

        // Clean press on ch0, then bounce-qualified press on ch1
        drive_ch(0, 1'b1, 10);
        begin
            bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 8; i++) drive_ch(1, pat[i], 1);
        end
        step(6);
        // Three-cycle glitches on ch3 never qualify
        for (int i = 0; i < 6; i++) begin
            drive_ch(3, 1'b1, 3);
            drive_ch(3, 1'b0, 2);
        end
        button[0] = 1'b0;
        drive_ch(1, 1'b0, 10);

        // Press / release / press on ch2
        drive_ch(2, 1'b1, 8);
        drive_ch(2, 1'b0, 8);
        drive_ch(2, 1'b1, 8);
        drive_ch(2, 1'b0, 8);

        // Long press: 15 held, 9 held, and exactly LC held (release wins)
        drive_ch(0, 1'b1, 15);
        drive_ch(0, 1'b0, 10);
        drive_ch(0, 1'b1, 9);
        drive_ch(0, 1'b0, 10);
        drive_ch(0, 1'b1, LC);
        drive_ch(0, 1'b0, 10);

        // Asynchronous reset while ch0 counter sits at 2
        drive_ch(2, 1'b1, 12);
        button[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({pressed, press_pulse, release_pulse, toggle, long_press} !== '0) begin
            fails++;
            $display("FAIL async_reset_clear got p=%b tg=%b pp=%b rp=%b lp=%b required all zero",
                     pressed, toggle, press_pulse, release_pulse, long_press);
        end
        step(3);
        rst_n = 1'b1;
        step(15);
        button = '0;
        step(10);

        // Randomised bouncing on all channels
        for (int c = 0; c < NUM_CH; c++) rem[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rem[c] == 0) begin
                    button[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 5))
                                                       : int'($urandom_range(6, 25));
                end
                rem[c]--;
            end
            step(1);
        end
        button = '0;
        step(20);

        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
